// File: rtl/adxl362_sequencer_if.sv
// Handshake bundle between adxl362_sequencer (master) and the single-byte SPI
// register controller (slave).
interface adxl362_sequencer_if;
  logic       ctl_start;
  logic       ctl_write;
  logic [7:0] ctl_address;
  logic [7:0] ctl_data_to_send;
  logic       ctl_busy;
  logic       ctl_done;
  logic [7:0] ctl_data_received;

  modport master (
    output ctl_start,
    output ctl_write,
    output ctl_address,
    output ctl_data_to_send,
    input  ctl_busy,
    input  ctl_done,
    input  ctl_data_received
  );

  modport slave (
    input  ctl_start,
    input  ctl_write,
    input  ctl_address,
    input  ctl_data_to_send,
    output ctl_busy,
    output ctl_done,
    output ctl_data_received
  );
endinterface

// File: rtl/adxl362_sequencer.sv
// ADXL362 autonomous sequencer: soft reset, measurement mode, then STATUS polling and
// X/Y/Z reads per sample tick. Optional DEVICEID check when ADXL362_ID_CHECK_EN is defined.
module adxl362_sequencer #(
  parameter int unsigned CLK_FREQUENCY     = 100_000_000,
  parameter int unsigned SAMPLE_RATE_HZ    = 100,
  parameter int unsigned RESET_WAIT_CYCLES = 50_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  adxl362_sequencer_if.master        ctl,
  output logic                       init_done,
  output logic [7:0]                 x_data,
  output logic [7:0]                 y_data,
  output logic [7:0]                 z_data,
  output logic [7:0]                 status,
  output logic                       sample_valid,
  output logic                       overrun,
  output logic                       id_error
);

  localparam int unsigned SamplePeriod = CLK_FREQUENCY / SAMPLE_RATE_HZ;

  localparam logic [7:0] RegDevId     = 8'h00;
  localparam logic [7:0] RegX         = 8'h08;
  localparam logic [7:0] RegY         = 8'h09;
  localparam logic [7:0] RegZ         = 8'h0A;
  localparam logic [7:0] RegStatus    = 8'h0B;
  localparam logic [7:0] RegSoftReset = 8'h1F;
  localparam logic [7:0] RegPowerCtl  = 8'h2D;
  localparam logic [7:0] SoftResetKey = 8'h52;
  localparam logic [7:0] MeasureMode  = 8'h02;
  localparam logic [7:0] DevIdValue   = 8'hAD;

  typedef enum logic [3:0] {
    StIdle,
    StSrst,
    StRstWait,
`ifdef ADXL362_ID_CHECK_EN
    StIdRd,
    StHalt,
`endif
    StPwr,
    StWaitTick,
    StRdStat,
    StRdX,
    StRdY,
    StRdZ,
    StPublish
  } state_e;

  state_e      state_q, state_d;
  logic        issued_q, issued_d;
  logic        start_q, start_d;
  logic        write_q, write_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        init_done_q, init_done_d;
  logic [7:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [7:0]  xs_q, xs_d, ys_q, ys_d, zs_q, zs_d;
  logic [7:0]  status_q, status_d;
  logic        sample_valid_q, sample_valid_d;
  logic        overrun_q, overrun_d;
  logic        id_error_q, id_error_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic        pending_q, pending_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  logic        txn_write;
  logic [7:0]  txn_addr;
  logic [7:0]  txn_data;
  logic        tick_wrap;
  logic        tick_clear;

  // Register access implied by each transaction state.
  always_comb begin
    txn_write = 1'b0;
    txn_addr  = 8'h00;
    txn_data  = 8'h00;
    case (state_q)
      StSrst:   begin txn_write = 1'b1; txn_addr = RegSoftReset; txn_data = SoftResetKey; end
      StPwr:    begin txn_write = 1'b1; txn_addr = RegPowerCtl;  txn_data = MeasureMode;  end
      StRdStat: txn_addr = RegStatus;
      StRdX:    txn_addr = RegX;
      StRdY:    txn_addr = RegY;
      StRdZ:    txn_addr = RegZ;
`ifdef ADXL362_ID_CHECK_EN
      StIdRd:   txn_addr = RegDevId;
`endif
      default:  ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    issued_d       = issued_q;
    start_d        = 1'b0;
    write_d        = write_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    init_done_d    = init_done_q;
    x_d            = x_q;
    y_d            = y_q;
    z_d            = z_q;
    xs_d           = xs_q;
    ys_d           = ys_q;
    zs_d           = zs_q;
    status_d       = status_q;
    sample_valid_d = 1'b0;
    overrun_d      = overrun_q;
    id_error_d     = id_error_q;
    tick_cnt_d     = tick_cnt_q;
    pending_d      = pending_q;
    wait_cnt_d     = wait_cnt_q;
    tick_wrap      = 1'b0;
    tick_clear     = 1'b0;

    // Sample tick: a clear and a wrap in the same cycle leave the tick pending.
    if (state_q == StIdle) begin
      tick_cnt_d = 32'd0;
      pending_d  = 1'b0;
    end else begin
      tick_wrap  = (tick_cnt_q == 32'(SamplePeriod - 1));
      tick_clear = (state_q == StWaitTick) && pending_q;
      tick_cnt_d = tick_wrap ? 32'd0 : tick_cnt_q + 32'd1;
      if (tick_clear) pending_d = 1'b0;
      if (tick_wrap) begin
        if (pending_q && !tick_clear) overrun_d = 1'b1;
        pending_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        init_done_d = 1'b0;
        issued_d    = 1'b0;
        if (run) begin
          overrun_d  = 1'b0;
          id_error_d = 1'b0;
          state_d    = StSrst;
        end
      end
      StRstWait: begin
        if (!run) begin
          state_d = StIdle;
        end else if (wait_cnt_q == 32'(RESET_WAIT_CYCLES - 1)) begin
          wait_cnt_d = 32'd0;
`ifdef ADXL362_ID_CHECK_EN
          state_d    = StIdRd;
`else
          state_d    = StPwr;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      StWaitTick: begin
        if (!run) state_d = StIdle;
        else if (pending_q) state_d = StRdStat;
      end
      StPublish: begin
        x_d            = xs_q;
        y_d            = ys_q;
        z_d            = zs_q;
        sample_valid_d = 1'b1;
        state_d        = StWaitTick;
      end
`ifdef ADXL362_ID_CHECK_EN
      StHalt: begin
        if (!run) state_d = StIdle;
      end
`endif
      default: begin
        // Transaction states: issue once when idle, then hold until done; never abort.
        if (!issued_q) begin
          if (!run) begin
            state_d = StIdle;
          end else if (!ctl.ctl_busy) begin
            start_d  = 1'b1;
            issued_d = 1'b1;
            write_d  = txn_write;
            addr_d   = txn_addr;
            wdata_d  = txn_data;
          end
        end else if (ctl.ctl_done) begin
          issued_d = 1'b0;
          case (state_q)
            StSrst: begin
              wait_cnt_d = 32'd0;
              state_d    = StRstWait;
            end
`ifdef ADXL362_ID_CHECK_EN
            StIdRd: begin
              if (ctl.ctl_data_received != DevIdValue) begin
                id_error_d = 1'b1;
                state_d    = StHalt;
              end else begin
                state_d = StPwr;
              end
            end
`endif
            StPwr: begin
              init_done_d = 1'b1;
              state_d     = StWaitTick;
            end
            StRdStat: begin
              status_d = ctl.ctl_data_received;
              state_d  = ctl.ctl_data_received[0] ? StRdX : StWaitTick;
            end
            StRdX: begin xs_d = ctl.ctl_data_received; state_d = StRdY;    end
            StRdY: begin ys_d = ctl.ctl_data_received; state_d = StRdZ;    end
            StRdZ: begin zs_d = ctl.ctl_data_received; state_d = StPublish; end
            default: state_d = StIdle;
          endcase
          if (!run) begin
            state_d     = StIdle;
            init_done_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      issued_q       <= 1'b0;
      start_q        <= 1'b0;
      write_q        <= 1'b0;
      addr_q         <= 8'h00;
      wdata_q        <= 8'h00;
      init_done_q    <= 1'b0;
      x_q            <= 8'h00;
      y_q            <= 8'h00;
      z_q            <= 8'h00;
      xs_q           <= 8'h00;
      ys_q           <= 8'h00;
      zs_q           <= 8'h00;
      status_q       <= 8'h00;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      id_error_q     <= 1'b0;
      tick_cnt_q     <= 32'd0;
      pending_q      <= 1'b0;
      wait_cnt_q     <= 32'd0;
    end else begin
      state_q        <= state_d;
      issued_q       <= issued_d;
      start_q        <= start_d;
      write_q        <= write_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      init_done_q    <= init_done_d;
      x_q            <= x_d;
      y_q            <= y_d;
      z_q            <= z_d;
      xs_q           <= xs_d;
      ys_q           <= ys_d;
      zs_q           <= zs_d;
      status_q       <= status_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      id_error_q     <= id_error_d;
      tick_cnt_q     <= tick_cnt_d;
      pending_q      <= pending_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  assign ctl.ctl_start        = start_q;
  assign ctl.ctl_write        = write_q;
  assign ctl.ctl_address      = addr_q;
  assign ctl.ctl_data_to_send = wdata_q;
  assign init_done            = init_done_q;
  assign x_data               = x_q;
  assign y_data               = y_q;
  assign z_data               = z_q;
  assign status               = status_q;
  assign sample_valid         = sample_valid_q;
  assign overrun              = overrun_q;
`ifdef ADXL362_ID_CHECK_EN
  assign id_error             = id_error_q;
`else
  assign id_error             = 1'b0;
`endif

endmodule

// File: tb/tb_adxl362_sequencer.sv
// Bench for adxl362_sequencer: behavioural SPI controller model with a register map,
// transaction and sample scoreboards compared against expected queues.
module tb_adxl362_sequencer;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        init_done, sample_valid, overrun, id_error;
  logic [7:0]  x_data, y_data, z_data, status;
  logic [53:0] all_outs;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  regmap [256];
  int unsigned busy_len = 8;
  logic [31:0] cyc = 32'd0;
  int unsigned done_cnt = 0;
  int unsigned proto_err = 0;
  logic [31:0] m_cnt;
  logic [7:0]  cur_addr;
  logic        cur_wr;
  txn_t        mon_t;
  txn_t        obs_q[$];
  txn_t        exp_q[$];
  logic [23:0] samp_q[$];
  logic [31:0] samp_cyc_q[$];

  adxl362_sequencer_if sif ();

  adxl362_sequencer #(
    .CLK_FREQUENCY    (1000),
    .SAMPLE_RATE_HZ   (10),
    .RESET_WAIT_CYCLES(20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .ctl         (sif.master),
    .init_done   (init_done),
    .x_data      (x_data),
    .y_data      (y_data),
    .z_data      (z_data),
    .status      (status),
    .sample_valid(sample_valid),
    .overrun     (overrun),
    .id_error    (id_error)
  );

  assign all_outs = {sif.ctl_start, sif.ctl_write, sif.ctl_address, sif.ctl_data_to_send,
                     init_done, x_data, y_data, z_data, status, sample_valid, overrun, id_error};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Controller model: busy for busy_len cycles after start, then a one-cycle done.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sif.ctl_busy          <= 1'b0;
      sif.ctl_done          <= 1'b0;
      sif.ctl_data_received <= 8'h00;
      m_cnt                 <= 32'd0;
      cur_addr              <= 8'h00;
      cur_wr                <= 1'b0;
    end else begin
      sif.ctl_done <= 1'b0;
      if (sif.ctl_start && sif.ctl_busy) proto_err <= proto_err + 1;
      if (sif.ctl_busy) begin
        if (m_cnt <= 32'd1) begin
          sif.ctl_busy          <= 1'b0;
          sif.ctl_done          <= 1'b1;
          sif.ctl_data_received <= cur_wr ? 8'h00 : regmap[cur_addr];
          done_cnt              <= done_cnt + 1;
        end else begin
          m_cnt <= m_cnt - 32'd1;
        end
      end else if (sif.ctl_start) begin
        sif.ctl_busy <= 1'b1;
        m_cnt        <= busy_len;
        cur_addr     <= sif.ctl_address;
        cur_wr       <= sif.ctl_write;
        mon_t = '{wr: sif.ctl_write, addr: sif.ctl_address, data: sif.ctl_data_to_send, cyc: cyc};
        obs_q.push_back(mon_t);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && sample_valid) begin
      samp_q.push_back({x_data, y_data, z_data});
      samp_cyc_q.push_back(cyc);
    end
  end

  task automatic push_exp(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    txn_t e;
    e = '{wr: wr, addr: addr, data: data, cyc: 32'd0};
    exp_q.push_back(e);
  endtask

  task automatic flush();
    obs_q.delete();
    exp_q.delete();
    samp_q.delete();
    samp_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (all_outs !== 54'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %014h, required 0", all_outs);
    end
  endtask

  task automatic test_init();
    txn_t e, o, first, second;
    int n;
    int unsigned base;
    first = '0;
    second = '0;
    flush();
    push_exp(1'b1, 8'h1F, 8'h52);
`ifdef ADXL362_ID_CHECK_EN
    push_exp(1'b0, 8'h00, 8'h00);
`endif
    push_exp(1'b1, 8'h2D, 8'h02);
    n = exp_q.size();
    base = done_cnt;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) run = 1'b1;
    @(negedge clk);
    vectors++;
    if (init_done !== 1'b0) begin
      miscompares++;
      $display("FAIL init_done_early: got %0b, required 0", init_done);
    end
    for (int i = 0; i < 600 && obs_q.size() < n; i++) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL init_txn%0d: got no transaction, required addr %02h", i, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (i == 0) first = o;
        if (i == 1) second = o;
        if (o.wr !== e.wr || o.addr !== e.addr || (e.wr && o.data !== e.data)) begin
          miscompares++;
          $display("FAIL init_txn%0d: got wr=%0b addr=%02h data=%02h, required wr=%0b addr=%02h data=%02h",
                   i, o.wr, o.addr, o.data, e.wr, e.addr, e.data);
        end
      end
    end
    vectors++;
    if (second.cyc - first.cyc < 32'(busy_len + 20)) begin
      miscompares++;
      $display("FAIL reset_wait_gap: got %0d cycles between starts, required >= %0d",
               second.cyc - first.cyc, busy_len + 20);
    end
    for (int i = 0; i < 200 && (done_cnt - base) < n; i++) @(negedge clk);
    @(negedge clk);
    vectors++;
    if (init_done !== 1'b1) begin
      miscompares++;
      $display("FAIL init_done_set: got %0b, required 1", init_done);
    end
  endtask

  task automatic test_sample();
    txn_t e, o;
    logic [7:0] rd_addrs [4];
    rd_addrs[0] = 8'h0B;
    rd_addrs[1] = 8'h08;
    rd_addrs[2] = 8'h09;
    rd_addrs[3] = 8'h0A;
    for (int i = 0; i < 400 && samp_q.size() == 0; i++) @(negedge clk);
    flush();
    for (int t = 0; t < 3; t++)
      for (int k = 0; k < 4; k++) push_exp(1'b0, rd_addrs[k], 8'h00);
    for (int i = 0; i < 400 && (obs_q.size() < 12 || samp_q.size() < 3); i++) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL sample_txn%0d: got no transaction, required addr %02h", i, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.wr !== 1'b0 || o.addr !== e.addr) begin
          miscompares++;
          $display("FAIL sample_txn%0d: got wr=%0b addr=%02h, required wr=0 addr=%02h",
                   i, o.wr, o.addr, e.addr);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (samp_q.size() <= i || samp_q[i] !== 24'h123456) begin
        miscompares++;
        $display("FAIL sample_value%0d: got %0d samples (%06h), required 123456",
                 i, samp_q.size(), (samp_q.size() > i) ? samp_q[i] : 24'h0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (samp_cyc_q.size() <= i + 1 || samp_cyc_q[i+1] - samp_cyc_q[i] !== 32'd100) begin
        miscompares++;
        $display("FAIL sample_spacing%0d: got %0d samples, spacing not 100 cycles", i,
                 samp_cyc_q.size());
      end
    end
    vectors++;
    if ({x_data, y_data, z_data, status} !== 32'h12345641) begin
      miscompares++;
      $display("FAIL sample_outputs: got xyz/status %02h %02h %02h %02h, required 12 34 56 41",
               x_data, y_data, z_data, status);
    end
  endtask

  task automatic test_no_data();
    txn_t o;
    regmap[8'h0B] = 8'h40;
    regmap[8'h08] = 8'h99;
    flush();
    repeat (300) @(negedge clk);
    vectors++;
    if (obs_q.size() != 3) begin
      miscompares++;
      $display("FAIL nodata_count: got %0d transactions, required 3", obs_q.size());
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      vectors++;
      if (o.wr !== 1'b0 || o.addr !== 8'h0B) begin
        miscompares++;
        $display("FAIL nodata_txn: got wr=%0b addr=%02h, required wr=0 addr=0b", o.wr, o.addr);
      end
    end
    vectors++;
    if (samp_q.size() != 0 || x_data !== 8'h12 || status !== 8'h40) begin
      miscompares++;
      $display("FAIL nodata_outputs: got %0d pulses x=%02h status=%02h, required 0 12 40",
               samp_q.size(), x_data, status);
    end
  endtask

  task automatic test_drop_run();
    int unsigned base;
    regmap[8'h0B] = 8'h41;
    regmap[8'h08] = 8'h77;
    regmap[8'h09] = 8'h78;
    regmap[8'h0A] = 8'h79;
    flush();
    base = done_cnt;
    for (int i = 0; i < 300 && (obs_q.size() == 0 || obs_q[obs_q.size()-1].addr != 8'h09); i++)
      @(negedge clk);
    run = 1'b0;
    repeat (40) @(negedge clk);
    vectors++;
    if (obs_q.size() != 3 || done_cnt - base != 3) begin
      miscompares++;
      $display("FAIL drop_rdy_complete: got %0d starts %0d dones, required 3 3",
               obs_q.size(), done_cnt - base);
    end
    vectors++;
    if (samp_q.size() != 0 || init_done !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_state: got %0d pulses init_done=%0b, required 0 0",
               samp_q.size(), init_done);
    end
    vectors++;
    if ({x_data, y_data, z_data, status} !== 32'h12345641) begin
      miscompares++;
      $display("FAIL drop_kept: got xyz/status %02h %02h %02h %02h, required 12 34 56 41",
               x_data, y_data, z_data, status);
    end
    repeat (100) @(negedge clk);
    vectors++;
    if (obs_q.size() != 3) begin
      miscompares++;
      $display("FAIL drop_no_start: got %0d starts, required 3", obs_q.size());
    end
  endtask

  task automatic test_overrun();
    busy_len = 150;
    flush();
    run = 1'b1;
    for (int i = 0; i < 600 && overrun !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set: got %0b, required 1", overrun);
    end
    repeat (200) @(negedge clk);
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_sticky: got %0b, required 1", overrun);
    end
    run = 1'b0;
    repeat (200) @(negedge clk);
    busy_len = 8;
    run = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear: got %0b, required 0", overrun);
    end
  endtask

  task automatic test_rst_mid();
    flush();
    for (int i = 0; i < 300 && obs_q.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++;
    if (sif.ctl_busy !== 1'b1 || x_data !== 8'h12) begin
      miscompares++;
      $display("FAIL rst_mid_pre: got busy=%0b x=%02h, required 1 12", sif.ctl_busy, x_data);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (all_outs !== 54'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got %014h, required 0", all_outs);
    end
    run = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

`ifdef ADXL362_ID_CHECK_EN
  task automatic test_id_check();
    regmap[8'h00] = 8'h00;
    flush();
    run = 1'b1;
    repeat (300) @(negedge clk);
    vectors++;
    if (obs_q.size() != 2 || obs_q[0].addr !== 8'h1F || obs_q[1].addr !== 8'h00 ||
        obs_q[1].wr !== 1'b0) begin
      miscompares++;
      $display("FAIL id_txns: got %0d transactions, required write 1f then read 00 only",
               obs_q.size());
    end
    vectors++;
    if (id_error !== 1'b1 || init_done !== 1'b0) begin
      miscompares++;
      $display("FAIL id_error_set: got id_error=%0b init_done=%0b, required 1 0",
               id_error, init_done);
    end
    run = 1'b0;
    repeat (20) @(negedge clk);
    run = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (id_error !== 1'b0) begin
      miscompares++;
      $display("FAIL id_error_clear: got %0b, required 0", id_error);
    end
    run = 1'b0;
    regmap[8'h00] = 8'hAD;
    repeat (50) @(negedge clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) regmap[i] = 8'h00;
    regmap[8'h00] = 8'hAD;
    regmap[8'h0B] = 8'h41;
    regmap[8'h08] = 8'h12;
    regmap[8'h09] = 8'h34;
    regmap[8'h0A] = 8'h56;
    test_reset();
    test_init();
    test_sample();
    test_no_data();
    test_drop_run();
    test_overrun();
    test_rst_mid();
`ifdef ADXL362_ID_CHECK_EN
    test_id_check();
`endif
    vectors++;
    if (proto_err != 0) begin
      miscompares++;
      $display("FAIL start_while_busy: got %0d, required 0", proto_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
